dist_sdpram_clr_v2: RTL and testbench

- Single-clock simple-dual-port distributed RAM for MFCC mel-bank coefficient and intermediate storage; next generation of the team's distributed SDPRAM.
- Adds per-lane write enables, 0/1/2-cycle read latency with a read-valid pipeline, and selectable read-during-write behaviour.
- Adds a hardware clear sequencer that zeroes the whole array after reset or on request, with a busy flag.
- Sits between the mel filterbank engine and the DCT/log stages.

---
 rtl/dist_sdpram_clr_v2_if.sv | 37 +++
 rtl/dist_sdpram_clr_v2.sv | 151 +++++++++++++++
 tb/tb_dist_sdpram_clr_v2.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_sdpram_clr_v2_if.sv
// Bus bundle for dist_sdpram_clr_v2: clear control, write port and read port.
// Defining DIST_SDPRAM_PARITY_EN adds the rd_par_err return signal.
interface dist_sdpram_clr_v2_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 1
);
    logic                  clr;
    logic                  busy;
    logic                  wr_en;
    logic [LANES-1:0]      wr_lane_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
`ifdef DIST_SDPRAM_PARITY_EN
    logic                  rd_par_err;
`endif

    modport master (
        output clr, wr_en, wr_lane_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
`ifdef DIST_SDPRAM_PARITY_EN
        , rd_par_err
`endif
    );

    modport slave (
        input  clr, wr_en, wr_lane_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid
`ifdef DIST_SDPRAM_PARITY_EN
        , rd_par_err
`endif
    );
endinterface

// File: rtl/dist_sdpram_clr_v2.sv
// Simple-dual-port distributed RAM with lane write enables, 0/1/2-cycle reads and a clear
// sequencer. Defining DIST_SDPRAM_PARITY_EN stores one even-parity bit per lane.
module dist_sdpram_clr_v2 #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned LANES        = 1,
    parameter int unsigned RD_LATENCY   = 1,
    parameter string       RDW_MODE     = "OLD",
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    dist_sdpram_clr_v2_if.slave bus
);
    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam int unsigned LaneW  = DATA_WIDTH / LANES;
    localparam bit          RdwNew = (RDW_MODE == "NEW");

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy, wr_go, rd_go, same_addr;
    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd1_q, rd2_q;
    logic                  vld1_q, vld2_q;

    assign busy      = (state_q == StClear);
    assign wr_go     = bus.wr_en & ~busy;
    assign rd_go     = bus.rd_en & ~busy;
    assign same_addr = (bus.wr_addr == bus.rd_addr);
    assign bus.busy  = busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clr) begin
            state_d = StClear;
            cnt_d   = '0;
        end else if (state_q == StClear) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = StIdle;
        end
    end

    // No reset on the array; the clear sequencer owns it while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (bus.wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wr_lane_en[k]) begin
                    mem_q[bus.wr_addr][k*LaneW +: LaneW] <= bus.wr_data[k*LaneW +: LaneW];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem_q[bus.rd_addr];
        if (RdwNew && wr_go && same_addr) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wr_lane_en[k]) rd_word[k*LaneW +: LaneW] = bus.wr_data[k*LaneW +: LaneW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RST ? StClear : StIdle;
            cnt_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rd_go) rd1_q <= rd_word;
            vld1_q  <= rd_go;
            if (vld1_q) rd2_q <= rd1_q;
            vld2_q  <= vld1_q;
        end
    end

    // With zero latency rd1_q only serves as the hold register between reads.
    always_comb begin
        if (RD_LATENCY == 0) begin
            bus.rd_data  = rd_go ? rd_word : rd1_q;
            bus.rd_valid = rd_go;
        end else if (RD_LATENCY == 1) begin
            bus.rd_data  = rd1_q;
            bus.rd_valid = vld1_q;
        end else begin
            bus.rd_data  = rd2_q;
            bus.rd_valid = vld2_q;
        end
    end

`ifdef DIST_SDPRAM_PARITY_EN
    logic [LANES-1:0] par_q [Depth];
    logic [LANES-1:0] wr_par, rd_par, rd_chk;
    logic             par_err, perr1_q, perr2_q;

    always_comb begin
        wr_par = '0;
        for (int k = 0; k < LANES; k++) wr_par[k] = ^bus.wr_data[k*LaneW +: LaneW];
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            par_q[cnt_q] <= '0;
        end else if (bus.wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wr_lane_en[k]) par_q[bus.wr_addr][k] <= wr_par[k];
            end
        end
    end

    always_comb begin
        rd_par = par_q[bus.rd_addr];
        rd_chk = '0;
        if (RdwNew && wr_go && same_addr) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wr_lane_en[k]) rd_par[k] = wr_par[k];
            end
        end
        for (int k = 0; k < LANES; k++) rd_chk[k] = (^rd_word[k*LaneW +: LaneW]) ^ rd_par[k];
    end

    assign par_err = |rd_chk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr1_q <= 1'b0;
            perr2_q <= 1'b0;
        end else begin
            perr1_q <= rd_go & par_err;
            perr2_q <= perr1_q;
        end
    end

    always_comb begin
        if (RD_LATENCY == 0)      bus.rd_par_err = rd_go & par_err;
        else if (RD_LATENCY == 1) bus.rd_par_err = perr1_q;
        else                      bus.rd_par_err = perr2_q;
    end
`endif
endmodule

// File: tb/tb_dist_sdpram_clr_v2.sv
// Bench for dist_sdpram_clr_v2: three instances (latency 0/NEW, 1/OLD, 2/NEW) driven in
// lockstep and compared against a word-level reference model.
module tb_dist_sdpram_clr_v2;
    localparam int DEPTH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr, wr_en, rd_en;
    logic [1:0]  wr_lane_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;

    logic [2:0]       bsy, rdv;
    logic [2:0][15:0] rdd;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        dist_sdpram_clr_v2_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANES(2)) bus ();
        assign bus.clr        = clr;
        assign bus.wr_en      = wr_en;
        assign bus.wr_lane_en = wr_lane_en;
        assign bus.wr_addr    = wr_addr;
        assign bus.wr_data    = wr_data;
        assign bus.rd_en      = rd_en;
        assign bus.rd_addr    = rd_addr;
        assign bsy[g]         = bus.busy;
        assign rdv[g]         = bus.rd_valid;
        assign rdd[g]         = bus.rd_data;

        dist_sdpram_clr_v2 #(
            .ADDR_WIDTH  (4),
            .DATA_WIDTH  (16),
            .LANES       (2),
            .RD_LATENCY  (g),
            .RDW_MODE    (g == 1 ? "OLD" : "NEW"),
            .CLEAR_ON_RST(1'b1)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] nw, logic [1:0] le);
        merge = old;
        if (le[0]) merge[7:0] = nw[7:0];
        if (le[1]) merge[15:8] = nw[15:8];
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, remaining clear cycles, expected read pipelines.
    logic [15:0] m_mem [DEPTH];
    int          m_left, m_addr;
    logic [15:0] e_hold0, e_d1, e_d2a, e_d2;
    logic        e_v1, e_v2a, e_v2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = DEPTH; m_addr = 0;
            e_hold0 = '0; e_d1 = '0; e_d2a = '0; e_d2 = '0;
            e_v1 = 1'b0; e_v2a = 1'b0; e_v2 = 1'b0;
        end else begin : step
            bit          busy_m, urd, uwr;
            logic [15:0] old, nw;
            busy_m = (m_left > 0);
            urd    = rd_en && !busy_m;
            uwr    = wr_en && !busy_m;
            old    = m_mem[rd_addr];
            nw     = (uwr && wr_addr == rd_addr) ? merge(old, wr_data, wr_lane_en) : old;
            if (urd) e_hold0 = nw;
            e_v1 = urd;
            if (urd) e_d1 = old;
            e_v2 = e_v2a;
            if (e_v2a) e_d2 = e_d2a;
            e_v2a = urd;
            if (urd) e_d2a = nw;
            if (busy_m) m_mem[m_addr] = '0;
            else if (uwr) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_lane_en);
            if (clr) begin
                m_left = DEPTH; m_addr = 0;
            end else if (busy_m) begin
                m_left--; m_addr++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit          b, v0;
            logic [15:0] d0;
            b  = (m_left > 0);
            v0 = rd_en && !b;
            d0 = e_hold0;
            if (v0) d0 = (wr_en && wr_addr == rd_addr) ?
                         merge(m_mem[rd_addr], wr_data, wr_lane_en) : m_mem[rd_addr];
            for (int g = 0; g < 3; g++) check($sformatf("busy%0d", g), 16'(bsy[g]), 16'(b));
            check("valid0", 16'(rdv[0]), 16'(v0));
            check("data0", rdd[0], d0);
            check("valid1", 16'(rdv[1]), 16'(e_v1));
            check("data1", rdd[1], e_d1);
            check("valid2", 16'(rdv[2]), 16'(e_v2));
            check("data2", rdd[2], e_d2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        clr = 0; wr_en = 0; rd_en = 0; wr_lane_en = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    // Counts busy cycles of the latency-1 instance; expects a full 16-cycle clear.
    task automatic count_busy(string name);
        int n = 0;
        @(negedge clk);
        while (bsy[1] && n < 64) begin
            n++;
            @(negedge clk);
        end
        #1;
        check(name, 16'(n), 16'd16);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  le;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Expected outputs of the latency-1 / OLD instance, starting from a cleared array.
        tbl[0] = '{1'b1, 2'b11, 4'd5, 16'hABCD, 1'b0, 4'd0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 2'b10, 4'd5, 16'h1200, 1'b1, 4'd5, 1'b1, 16'hABCD};
        tbl[2] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 16'h12CD};
        tbl[3] = '{1'b1, 2'b11, 4'd3, 16'h1111, 1'b1, 4'd0, 1'b1, 16'h0000};
        tbl[4] = '{1'b1, 2'b11, 4'd3, 16'h5555, 1'b1, 4'd3, 1'b1, 16'h1111};
        tbl[5] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h1111};
        tbl[6] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h5555};
        tbl[7] = '{1'b1, 2'b00, 4'd3, 16'hFFFF, 1'b1, 4'd3, 1'b1, 16'h5555};
        tbl[8] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h5555};
        tbl[9] = '{1'b0, 2'b11, 4'd7, 16'hBEEF, 1'b1, 4'd7, 1'b1, 16'h0000};

        idle_in();
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy("busy_after_rst");

        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1; rd_addr = 4'(a);
            cyc();
            check("clear_rd_valid", 16'(rdv[1]), 16'd1);
            check("clear_rd_data", rdd[1], 16'h0000);
        end
        idle_in();
        cyc();

        for (int i = 0; i < 10; i++) begin
            wr_en = tbl[i].we; wr_lane_en = tbl[i].le; wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd; rd_en = tbl[i].re; rd_addr = tbl[i].ra;
            cyc();
            check($sformatf("tbl%0d_valid", i), 16'(rdv[1]), 16'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i), rdd[1], tbl[i].ed);
        end
        idle_in();
        cyc();

        // clr restarts the sequence at cnt 7; user traffic during busy must be dropped.
        clr = 1;
        cyc();
        clr = 0;
        repeat (7) cyc();
        clr = 1; wr_en = 1; wr_lane_en = 2'b11; wr_addr = 4'd9; wr_data = 16'hDEAD;
        rd_en = 1; rd_addr = 4'd9;
        cyc();
        clr = 0;
        count_busy("busy_clr_restart");
        idle_in();
        rd_en = 1; rd_addr = 4'd9;
        cyc();
        idle_in();
        check("post_clr_valid", 16'(rdv[1]), 16'd1);
        check("post_clr_data", rdd[1], 16'h0000);

        // Asynchronous reset while a read is in flight.
        wr_en = 1; wr_lane_en = 2'b11; wr_addr = 4'd5; wr_data = 16'h1234;
        cyc();
        idle_in();
        rd_en = 1; rd_addr = 4'd5;
        cyc();
        rd_en = 0;
        check("pre_rst_valid", 16'(rdv[1]), 16'd1);
        check("pre_rst_data", rdd[1], 16'h1234);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid1", 16'(rdv[1]), 16'd0);
        check("rst_data1", rdd[1], 16'h0000);
        check("rst_valid2", 16'(rdv[2]), 16'd0);
        check("rst_data2", rdd[2], 16'h0000);
        check("rst_busy", 16'(bsy[1]), 16'd1);
        cyc();
        rst_n = 1'b1;
        count_busy("busy_after_midrst");

`ifdef DIST_SDPRAM_PARITY_EN
        wr_en = 1; wr_lane_en = 2'b11; wr_addr = 4'd5; wr_data = 16'h00FF;
        cyc();
        wr_addr = 4'd6;
        cyc();
        idle_in();
        gen_dut[0].dut.mem_q[5][0] <= 1'b0;
        gen_dut[1].dut.mem_q[5][0] <= 1'b0;
        gen_dut[2].dut.mem_q[5][0] <= 1'b0;
        m_mem[5] = 16'h00FE;
        cyc();
        rd_en = 1; rd_addr = 4'd5;
        cyc();
        check("par_flip_valid", 16'(rdv[1]), 16'd1);
        check("par_flip_err", 16'(gen_dut[1].bus.rd_par_err), 16'd1);
        rd_addr = 4'd6;
        cyc();
        check("par_ok_err", 16'(gen_dut[1].bus.rd_par_err), 16'd0);
        idle_in();
        cyc();
`endif

        repeat (400) begin
            clr        = ($urandom_range(0, 49) == 0);
            wr_en      = 1'($urandom_range(0, 1));
            wr_lane_en = 2'($urandom);
            wr_addr    = 4'($urandom);
            wr_data    = 16'($urandom);
            rd_en      = 1'($urandom_range(0, 1));
            rd_addr    = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
            cyc();
        end
        idle_in();
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
